// File: rtl/div_pkg.sv
// Shared types and constants for the divider request front-end.
package div_pkg;

  localparam int DIV_W = 4;

  // Quotient reported for a zero divisor.
  localparam logic [DIV_W-1:0] DZ_QUOT = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } div_state_t;

  typedef struct packed {
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
  } div_req_t;

endpackage

// File: rtl/div_req_fifo.sv
// DEPTH-entry request FIFO; wrap-bit pointers; head reads as zero when empty.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  div_req_t wdata,
  output div_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  div_req_t    mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  // A push into a full FIFO is dropped even if a pop frees a slot this edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  // Storage array; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
    end
  end

endmodule

// File: rtl/div_issue_queue.sv
// Divider front-end: queues requests, launches them, holds one result.
module div_issue_queue
  import div_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIV_W-1:0] in_dividend,
  input  logic [DIV_W-1:0] in_divisor,
  output logic             div_start,
  output logic [DIV_W-1:0] div_dividend,
  output logic [DIV_W-1:0] div_divisor,
  input  logic             div_ready,
  input  logic [DIV_W-1:0] div_quot,
  input  logic [DIV_W-1:0] div_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] out_quot,
  output logic [DIV_W-1:0] out_rem,
  output logic             out_dz,
  output logic             busy
);

  div_state_t state, state_n;
  div_req_t   req, head;
  logic       full, empty, pop, slot_free, load_dz, load_div;

  assign req          = {in_dividend, in_divisor};
  assign in_ready     = !full;
  assign div_dividend = head.dividend;
  assign div_divisor  = head.divisor;
  // Result slot can take a new value at this edge.
  assign slot_free    = !out_valid || out_ready;
  assign busy         = !empty || (state != IDLE) || out_valid;

  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .pop   (pop),
    .wdata (req),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Launch/complete control. Launch only with a free slot so a completion
  // always has somewhere to land; zero divisors bypass the divider.
  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    div_start = 1'b0;
    load_dz   = 1'b0;
    load_div  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && slot_free) begin
          if (head.divisor == '0) begin
            pop     = 1'b1;
            load_dz = 1'b1;
          end else begin
            div_start = 1'b1;
            if (div_ready) begin
              pop     = 1'b1;
              state_n = WAIT;
            end
          end
        end
      end
      WAIT: begin
        // Quotient is only valid in the completion cycle; capture now.
        if (div_ready) begin
          load_div = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Result register; a new result wins over consumption in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_dz    <= 1'b0;
    end else if (load_dz) begin
      out_valid <= 1'b1;
      out_quot  <= DZ_QUOT;
      out_rem   <= head.dividend;
      out_dz    <= 1'b1;
    end else if (load_div) begin
      out_valid <= 1'b1;
      out_quot  <= div_quot;
      out_rem   <= div_rem;
      out_dz    <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: divider model, in-order result scoreboard,
// directed timing cases and a randomized traffic phase.
module tb_div_issue_queue;
  import div_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] in_dividend = '0, in_divisor = '0;
  logic       in_ready, div_start, div_ready, out_valid, out_dz, busy;
  logic [3:0] div_dividend, div_divisor, div_quot, div_rem, out_quot, out_rem;

  always #5 clk = ~clk;

  div_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ready    (div_ready),
    .div_quot     (div_quot),
    .div_rem      (div_rem),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quot     (out_quot),
    .out_rem      (out_rem),
    .out_dz       (out_dz),
    .busy         (busy)
  );

  int n_chk = 0, n_fail = 0, n_res = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Divider model: ready when idle; after a launch, ready low for 4 cycles,
  // then one completion cycle carrying the answer. Garbage otherwise.
  // It is not reset by rst_n, so it can finish a divide the DUT abandoned.
  int         dcnt = 0;
  logic       hold = 1'b0, inflight = 1'b0;
  logic [3:0] dq = '0, dr = '0, gq = '0, gr = '0;
  assign div_ready = !hold && (dcnt <= 1);
  assign div_quot  = (dcnt == 1) ? dq : gq;
  assign div_rem   = (dcnt == 1) ? dr : gr;

  always @(posedge clk) begin
    gq <= 4'($urandom);
    gr <= 4'($urandom);
    if (div_start && div_ready) begin
      dcnt     <= 5;
      inflight <= 1'b1;
      dq       <= (div_divisor == 0) ? 4'hF : div_dividend / div_divisor;
      dr       <= (div_divisor == 0) ? div_dividend : div_dividend % div_divisor;
    end else begin
      if (dcnt == 1) inflight <= 1'b0;
      if (dcnt > 0)  dcnt <= dcnt - 1;
    end
    if (!rst_n) inflight <= 1'b0;
  end

  // Scoreboard: every accepted request yields exactly one result, in order.
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } res_t;
  res_t sb[$];
  res_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      chk("busy", busy, sb.size() != 0);
      if (out_valid) chk("ov_unexpected", sb.size() != 0, 1);
      if (div_start) begin
        chk("start_in_flight", inflight, 0);
        chk("start_blocked", out_valid && !out_ready, 0);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_quot", out_quot, e.q);
        chk("res_rem", out_rem, e.r);
        chk("res_dz", out_dz, e.dz);
        n_res++;
      end
      if (in_valid && in_ready) begin
        if (in_divisor == 0) e = '{q: 4'hF, r: in_dividend, dz: 1'b1};
        else e = '{q: in_dividend / in_divisor, r: in_dividend % in_divisor, dz: 1'b0};
        sb.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (!busy) break;
      cyc();
    end
    chk(tag, busy, 0);
    chk({tag, "_sb"}, sb.size(), 0);
  endtask

  task automatic wait_ov(input string tag);
    for (int k = 0; k < 30; k++) begin
      if (out_valid) break;
      cyc();
    end
    chk(tag, out_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, got;
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_ov", out_valid, 0);
    chk("rst_quot", out_quot, 0);
    chk("rst_rem", out_rem, 0);
    chk("rst_dz", out_dz, 0);
    chk("rst_start", div_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_head", div_dividend, 0);
    rst_n = 1'b1;
    cyc();

    // 13/3: start only in cycle 1, result in cycle 7.
    out_ready = 1'b1;
    push1(4'd13, 4'd3);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1 in_valid = 1'b0; #1;
      chk("t1_start", div_start, c == 1);
      chk("t1_ov", out_valid, c == 7);
      if (c == 7) begin
        chk("t1_quot", out_quot, 4);
        chk("t1_rem", out_rem, 1);
        chk("t1_dz", out_dz, 0);
      end
    end

    // 9/0: resolved locally, result in cycle 2, divider untouched.
    push1(4'd9, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1 in_valid = 1'b0; #1;
      chk("t2_start", div_start, 0);
      chk("t2_ov", out_valid, c == 2);
      if (c == 2) begin
        chk("t2_quot", out_quot, 4'hF);
        chk("t2_rem", out_rem, 9);
        chk("t2_dz", out_dz, 1);
      end
    end
    wait_idle("t2_idle");

    // Divider busy for 10 cycles: start held, head kept, no result.
    hold = 1'b1;
    push1(4'd12, 4'd5);
    cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("t4_start", div_start, 1);
      chk("t4_ov", out_valid, 0);
      chk("t4_head", {div_dividend, div_divisor}, {4'd12, 4'd5});
      cyc();
    end
    hold = 1'b0;
    wait_ov("t4_done");
    wait_idle("t4_idle");

    // Fill with the divider stalled, overflow, then in-order drain.
    base = n_res;
    hold = 1'b1;
    out_ready = 1'b0;
    push1(4'd15, 4'd4); chk("t3_rdy0", in_ready, 1); cyc();
    push1(4'd7, 4'd7);  chk("t3_rdy1", in_ready, 1); cyc();
    push1(4'd2, 4'd5);  chk("t3_rdy2", in_ready, 1); cyc();
    push1(4'd8, 4'd0);  chk("t3_rdy3", in_ready, 1); cyc();
    chk("t3_full", in_ready, 0);
    push1(4'd6, 4'd1);
    for (int c = 0; c < 3; c++) begin
      #1 chk("t3_refused", in_ready, 0);
      cyc();
    end
    hold = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin
      #1 got = int'(in_ready);
      cyc();
    end
    in_valid = 1'b0;
    chk("t3_accept", got, 1);
    wait_ov("t3_first");
    // Result parked: no launch until the slot frees.
    for (int c = 0; c < 3; c++) begin
      #1 chk("t5_no_start", div_start, 0);
      chk("t5_held", out_valid, 1);
      cyc();
    end
    out_ready = 1'b1;
    #1 chk("t5_start_same", div_start, 1);
    cyc();
    chk("t5_launched", inflight, 1);
    wait_idle("t3_idle");
    chk("t3_count", n_res - base, 5);

    // Reset in the 3rd WAIT cycle; the stale completion must be ignored.
    push1(4'd11, 4'd2);
    cyc(); in_valid = 1'b0;
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_ov", out_valid, 0);
    chk("t6_quot", out_quot, 0);
    chk("t6_rem", out_rem, 0);
    chk("t6_dz", out_dz, 0);
    chk("t6_start", div_start, 0);
    chk("t6_busy", busy, 0);
    cyc();
    rst_n = 1'b1;
    push1(4'd14, 4'd3);
    cyc(); in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("t6_stale", out_valid, 0);
      cyc();
    end
    wait_ov("t6_next");
    chk("t6_next_quot", out_quot, 4);
    wait_idle("t6_idle");

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      in_valid    = $urandom_range(1, 0) == 1;
      in_dividend = 4'($urandom);
      in_divisor  = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom);
      out_ready   = $urandom_range(3, 0) != 0;
      hold        = (dcnt == 0) && ($urandom_range(3, 0) == 0);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1; hold = 1'b0;
    wait_idle("rand_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
